// File: rtl/semaforo_pkg.sv
// Shared lamp encodings and controller state for the semaforo light
// and its upstream sequencing controller.
package semaforo_pkg;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_RED    = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b100;
  localparam logic [2:0] LAMP_ERROR  = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GREEN,
    S_TO_RED,
    S_RED,
    S_TO_GREEN,
    S_FAULT
  } ctrl_state_t;

  function automatic logic multi_lit(input logic [2:0] l);
    return (l[0] & l[1]) | (l[0] & l[2]) | (l[1] & l[2]);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer:
// btn_db only moves after DEB_CYCLES identical synchronized samples.
module btn_debounce
  import semaforo_pkg::*;
#(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_db
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_db  <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btn_db = r_db;

endmodule

// File: rtl/semaforo_ctrl.sv
// Sequencer for the semaforo light: green/red dwell, pedestrian
// shortening of green, lamp-feedback supervision with sticky fault.
module semaforo_ctrl
  import semaforo_pkg::*;
#(
  parameter int   DEB_CYCLES = 1000,
  parameter int   MIN_GREEN  = 50000,
  parameter int   MAX_GREEN  = 200000,
  parameter int   RED_TIME   = 40000,
  parameter int   XFER_TMO   = 65535,
  parameter logic START_RED  = 1'b1,
  parameter int   CNT_W      = 18
) (
  input  logic clklf,
  input  logic reset,
  input  logic en_in,
  input  logic btn,
  input  logic green,
  input  logic yellow,
  input  logic red,
  output logic en,
  output logic set,
  output logic change,
  output logic ped_wait,
  output logic fault
);

  localparam logic [CNT_W-1:0] P_MIN = CNT_W'(MIN_GREEN);
  localparam logic [CNT_W-1:0] P_MAX = CNT_W'(MAX_GREEN);
  localparam logic [CNT_W-1:0] P_RED = CNT_W'(RED_TIME);
  localparam logic [CNT_W-1:0] P_TMO = CNT_W'(XFER_TMO);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] w_dwell_nxt;
  logic [CNT_W-1:0] w_dwell_inc;
  logic [CNT_W-1:0] r_tmo;
  logic [CNT_W-1:0] w_tmo_nxt;
  logic [CNT_W-1:0] w_tmo_inc;
  logic             r_change;
  logic             w_change_nxt;
  logic             r_en;
  logic             r_fault;
  logic             r_ped_req;
  logic             r_db_q;
  logic             w_btn_db;
  logic             w_enter_red;
  logic [2:0]       w_fb;
  logic             w_multi;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk   (clklf),
    .reset (reset),
    .btn   (btn),
    .btn_db(w_btn_db)
  );

  assign w_fb        = {green, yellow, red};
  assign w_multi     = multi_lit(w_fb);
  assign w_dwell_inc = (&r_dwell) ? r_dwell : r_dwell + 1'b1;
  assign w_tmo_inc   = (&r_tmo) ? r_tmo : r_tmo + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_dwell_nxt  = r_dwell;
    w_tmo_nxt    = r_tmo;
    w_change_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_dwell_nxt = '0;
        w_tmo_nxt   = '0;
        if (en_in && w_fb == LAMP_GREEN) w_state_nxt = S_GREEN;
        else if (en_in && w_fb == LAMP_RED) w_state_nxt = S_RED;
      end
      S_GREEN: begin
        if (w_fb != LAMP_GREEN) begin
          w_state_nxt = S_FAULT;
        end else if ((r_dwell >= P_MIN && r_ped_req) ||
                     r_dwell >= P_MAX) begin
          w_change_nxt = 1'b1;
          w_state_nxt  = S_TO_RED;
          w_tmo_nxt    = '0;
        end else begin
          w_dwell_nxt = w_dwell_inc;
        end
      end
      S_TO_RED: begin
        if (w_multi) begin
          w_state_nxt = S_FAULT;
        end else if (w_fb == LAMP_RED) begin
          w_state_nxt = S_RED;
          w_dwell_nxt = '0;
        end else if (r_tmo >= P_TMO) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end
      S_RED: begin
        if (w_fb != LAMP_RED) begin
          w_state_nxt = S_FAULT;
        end else if (r_dwell >= P_RED) begin
          w_change_nxt = 1'b1;
          w_state_nxt  = S_TO_GREEN;
          w_tmo_nxt    = '0;
        end else begin
          w_dwell_nxt = w_dwell_inc;
        end
      end
      S_TO_GREEN: begin
        if (w_multi) begin
          w_state_nxt = S_FAULT;
        end else if (w_fb == LAMP_GREEN) begin
          w_state_nxt = S_GREEN;
          w_dwell_nxt = '0;
        end else if (r_tmo >= P_TMO) begin
          w_state_nxt = S_FAULT;
        end else begin
          w_tmo_nxt = w_tmo_inc;
        end
      end
      S_FAULT: w_state_nxt = S_FAULT;
      default: w_state_nxt = S_FAULT;
    endcase
    // a fault detected this cycle outranks the operator disable
    if (!en_in && w_state_nxt != S_FAULT) begin
      w_state_nxt  = S_IDLE;
      w_change_nxt = 1'b0;
      w_dwell_nxt  = '0;
      w_tmo_nxt    = '0;
    end
  end

  assign w_enter_red = (w_state_nxt == S_RED) && (r_state != S_RED);

  always_ff @(posedge clklf) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_dwell   <= '0;
      r_tmo     <= '0;
      r_change  <= 1'b0;
      r_en      <= 1'b0;
      r_fault   <= 1'b0;
      r_ped_req <= 1'b0;
      r_db_q    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_dwell  <= w_dwell_nxt;
      r_tmo    <= w_tmo_nxt;
      r_change <= w_change_nxt;
      r_fault  <= (w_state_nxt == S_FAULT);
      r_en     <= en_in && (w_state_nxt != S_FAULT);
      r_db_q   <= w_btn_db;
      if (!en_in || w_enter_red) r_ped_req <= 1'b0;
      else if (w_btn_db && !r_db_q) r_ped_req <= 1'b1;
    end
  end

  assign en       = r_en;
  assign set      = START_RED;
  assign change   = r_change;
  assign ped_wait = r_ped_req;
  assign fault    = r_fault;

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed bench for semaforo_ctrl with a behavioural semaforo
// model (green -> yellow -> red -> green) closing the loop.
module tb_semaforo_ctrl;
  import semaforo_pkg::*;

  logic clk = 1'b0;
  logic reset, en_in, btn;
  logic en, set, change, ped_wait, fault;
  logic g, y, r;
  logic force_err, ignore;
  logic [2:0] col = LAMP_RED;

  int n_cmp = 0;
  int n_bad = 0;
  int n;
  logic saw;

  always #5 clk = ~clk;

  semaforo_ctrl #(
    .DEB_CYCLES(4),
    .MIN_GREEN (20),
    .MAX_GREEN (50),
    .RED_TIME  (30),
    .XFER_TMO  (100),
    .START_RED (1'b1),
    .CNT_W     (18)
  ) dut (
    .clklf   (clk),
    .reset   (reset),
    .en_in   (en_in),
    .btn     (btn),
    .green   (g),
    .yellow  (y),
    .red     (r),
    .en      (en),
    .set     (set),
    .change  (change),
    .ped_wait(ped_wait),
    .fault   (fault)
  );

  assign {g, y, r} = force_err ? LAMP_ERROR : col;

  always @(posedge clk) begin
    if (reset) col <= LAMP_RED;
    else if (en) begin
      if (col == LAMP_YELLOW) col <= LAMP_RED;
      else if (change && !ignore) begin
        if (col == LAMP_GREEN) col <= LAMP_YELLOW;
        else if (col == LAMP_RED) col <= LAMP_GREEN;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic wait_chg(input int lim, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!change && cnt < lim);
  endtask

  task automatic wait_flt(input int lim, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!fault && cnt < lim);
  endtask

  initial begin
    reset = 1'b1; en_in = 1'b0; btn = 1'b0;
    force_err = 1'b0; ignore = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_en", en, 0);
    chk("rst_set", set, 1);
    chk("rst_chg", change, 0);
    chk("rst_pw", ped_wait, 0);
    chk("rst_flt", fault, 0);

    // power-up in red, free-running cycle without button
    reset = 1'b0; en_in = 1'b1;
    @(negedge clk);
    chk("en_lat", en, 1);
    wait_chg(200, n); chk("red_dwell", n, 31);
    wait_chg(200, n); chk("grn_max", n, 53);
    wait_chg(200, n); chk("red_dwell2", n, 34);

    // pedestrian press at green dwell 5
    repeat (7) @(negedge clk);
    btn = 1'b1;
    repeat (6) @(negedge clk);
    chk("pw_early", ped_wait, 0);
    @(negedge clk);
    chk("pw_lat", ped_wait, 1);
    wait_chg(200, n); chk("grn_ped", n, 9);
    repeat (2) @(negedge clk);
    chk("pw_hold", ped_wait, 1);
    @(negedge clk);
    chk("pw_clr", ped_wait, 0);
    btn = 1'b0;
    wait_chg(200, n); chk("red_dwell3", n, 31);

    // bouncing button must be rejected
    saw = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= 40 && n % 2 == 0) btn = ~btn;
      if (ped_wait) saw = 1'b1;
    end while (!change && n < 200);
    chk("bnc_pw", saw, 0);
    chk("bnc_grn", n, 53);

    // all lamps lit while red
    repeat (5) @(negedge clk);
    force_err = 1'b1;
    @(negedge clk);
    chk("flt_set", fault, 1);
    chk("flt_en", en, 0);
    en_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("flt_stk0", fault, 1);
    en_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("flt_stk1", fault, 1);
    chk("flt_en1", en, 0);
    chk("flt_chg", change, 0);
    force_err = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst2_flt", fault, 0);
    chk("rst2_en", en, 0);
    chk("rst2_pw", ped_wait, 0);

    // light ignores change while green
    reset = 1'b0;
    wait_chg(200, n); chk("tmo_red", n, 32);
    wait_chg(200, n); chk("tmo_grn", n, 53);
    ignore = 1'b1;
    wait_flt(300, n); chk("tmo_flt", n, 101);
    chk("tmo_en", en, 0);
    ignore = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // disable at green dwell 30, then resume
    reset = 1'b0;
    wait_chg(200, n); chk("dis_red", n, 32);
    repeat (32) @(negedge clk);
    en_in = 1'b0;
    @(negedge clk);
    chk("dis_en", en, 0);
    chk("dis_chg", change, 0);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (change) saw = 1'b1;
    end
    chk("dis_quiet", saw, 0);
    en_in = 1'b1;
    @(negedge clk);
    chk("reen_en", en, 1);
    wait_chg(200, n); chk("reen_grn", n, 51);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/semaforo_ctrl.md
# semaforo_ctrl

Sequencing controller placed directly upstream of the `semaforo` light FSM. Drives its `en`, `set` and `change` inputs and reads back its `green`/`yellow`/`red` outputs. Enforces minimum and maximum green dwell, fixed red dwell, and a debounced pedestrian request that shortens green. It also detects lamp-feedback faults and shuts the light down until reset.

## Interface
- `DEB_CYCLES`, 1000: consecutive stable cycles required to accept a button level
- `MIN_GREEN`, 50000: minimum green dwell (clklf cycles) before a pedestrian request is honoured
- `MAX_GREEN`, 200000: green dwell after which `change` is forced
- `RED_TIME`, 40000: red dwell before `change` is issued
- `XFER_TMO`, 65535: maximum cycles allowed for a commanded transition to appear on feedback
- `START_RED`, 1: value driven on `set`; 1 = light powers up in red
- `CNT_W`, 18: dwell/timeout counter width; must hold the largest of the above
- `clklf`  in  1  single clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high
- `en_in`  in  1  master enable from the operator
- `btn`  in  1  raw pedestrian push-button, asynchronous, active-high
- `green`, `yellow`, `red`  in  1 each  lamp feedback from `semaforo`
- `en`  out  1  enable to `semaforo`; equals `en_in & ~fault`, registered
- `set`  out  1  start colour to `semaforo`; constant `START_RED`
- `change`  out  1  one-cycle request to advance `semaforo`
- `ped_wait`  out  1  pedestrian request pending (wait lamp)
- `fault`  out  1  sticky fault flag

## Operation
- Button path: 2-FF synchronizer, then debouncer. Debounced level `btn_db` follows the synchronized input only after `DEB_CYCLES` identical consecutive samples. A rising edge of `btn_db` sets `ped_req`.
- `ped_req` clears on the cycle the FSM enters S_RED. It is also cleared by `reset` and by `en_in` low.
- The FSM has six states:
  - S_IDLE: `dwell` = 0.
    - If `en_in` and the feedback is exactly green, go to S_GREEN.
    - If `en_in` and the feedback is exactly red, go to S_RED.
    - Otherwise stay in S_IDLE.
  - S_GREEN: `dwell` increments.
    - If (`dwell` ≥ `MIN_GREEN` & `ped_req`) | `dwell` ≥ `MAX_GREEN`, pulse `change` and go to S_TO_RED.
  - S_TO_RED: `tmo` increments.
    - Feedback exactly red: go to S_RED with `dwell` = 0.
    - `tmo` ≥ `XFER_TMO`: go to S_FAULT.
  - S_RED: `dwell` increments.
    - `dwell` ≥ `RED_TIME`: pulse `change` and go to S_TO_GREEN.
  - S_TO_GREEN: mirror of S_TO_RED, waiting for feedback exactly green.
  - S_FAULT: absorbing; only `reset` exits.
- Fault entry from any state except S_IDLE:
  - more than one lamp lit (includes 3'b111 from the `semaforo` error state);
  - an unexpected colour, e.g. yellow or red in S_GREEN, or green in S_RED;
  - a transition timeout.
- `fault` is sticky and forces `en` low.
- `en_in` low in any non-fault state: go to S_IDLE next cycle; `change` = 0; counters and `ped_req` cleared.
- Counters saturate at all-ones and never wrap.
- Simultaneous events, by priority:
  - `reset` over fault, fault over `en_in`, `en_in` over the `change` decision.
  - A button edge in the same cycle as S_RED entry is dropped (clear wins).

## Timing
- Reset values: `en`=0, `set`=`START_RED`, `change`=0, `ped_wait`=0, `fault`=0; state S_IDLE; all counters 0.
- Button latency: raw edge to `ped_wait` high = 2 (sync) + `DEB_CYCLES` + 1 cycles.
- `change`:
  - registered; high for exactly one cycle, the cycle after the decision edge;
  - never asserted in two consecutive cycles;
  - never asserted outside S_GREEN/S_RED decisions.
- `fault` rises one cycle after the offending feedback sample or the timeout.
- `en` follows `en_in` with one cycle of latency.
- `ped_wait` = `ped_req`, registered.

## Structure
- Shared package `semaforo_pkg` holds:
  - the lamp encodings RED=3'b001, YELLOW=3'b010, GREEN=3'b100, OFF, ERROR, shared with `semaforo`;
  - the controller state encoding.
- One sub-module, `btn_debounce`: synchronizer plus stable-count debouncer, parameter `DEB_CYCLES`, output `btn_db`.
- The FSM, dwell/timeout counters and fault logic live in `semaforo_ctrl`.

## Test plan
All scenarios use parameters DEB_CYCLES=4, MIN_GREEN=20, MAX_GREEN=50, RED_TIME=30, XFER_TMO=100, with a behavioural `semaforo` model.
- Start, no button: `reset` high 2 cycles, then `en_in`=1, `set`=1.
  - The model reports red, so the FSM enters S_RED.
  - `change` pulses after 30 red cycles.
  - After green appears with no button, `change` pulses at dwell 50.
  - Pattern repeats.
- Button during green: press at green dwell 5.
  - `ped_wait` high 7 cycles later.
  - `change` at dwell 20.
  - `ped_wait` drops on red entry.
- Bounce rejection: `btn` toggles every 2 cycles for 40 cycles.
  - `ped_wait` stays 0.
  - Green lasts the full 50 cycles.
- Feedback fault: model drives {g,y,r}=3'b111 in S_RED.
  - `fault`=1 and `en`=0 within 2 cycles.
  - `fault` stays 1 with `en_in` toggled.
  - `reset` clears it.
- Transition timeout: model ignores `change` and holds green.
  - `fault` asserts 100 cycles after S_TO_RED entry.
- Mid-operation disable: `en_in`=0 at green dwell 30.
  - `en`=0 next cycle, no `change`, state S_IDLE.
  - Re-enable resumes from fed-back colour with `dwell`=0.
